// File: rtl/fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// fifo_sync_flags
//
// Single-clock FIFO with a fill-level count, programmable almost-full and
// almost-empty thresholds, and sticky overflow/underflow error flags.
// Storage is a simple dual-port array with a registered read port. All status
// outputs are decoded from the registered count, so they never follow the
// request inputs combinationally.
//
// Parameters
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries, power of two, >= 4
//   AF_LEVEL  Almost_full  when count >= AF_LEVEL (1 .. DEPTH)
//   AE_LEVEL  Almost_empty when count <= AE_LEVEL (0 .. DEPTH-1)
//
// Ports
//   CLK           clock, all state updates on the rising edge
//   RST_n         asynchronous active-low reset
//   EN_w          write request (accepted when not Full)
//   data_in       write data
//   EN_r          read request (accepted when not Empty)
//   CLR_err       clears Overflow/Underflow (a same-cycle set wins)
//   data_out      registered read data, holds between accepted reads
//   Full          count == DEPTH
//   Empty         count == 0
//   Almost_full   count >= AF_LEVEL
//   Almost_empty  count <= AE_LEVEL
//   count         number of stored words
//   Overflow      sticky: write requested while Full
//   Underflow     sticky: read requested while Empty
// -----------------------------------------------------------------------------
module fifo_sync_flags #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 8,
  parameter int AE_LEVEL = 8
) (
  input  logic                       CLK,
  input  logic                       RST_n,
  input  logic                       EN_w,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       EN_r,
  input  logic                       CLR_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Almost_full,
  output logic                       Almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Storage: no reset, so it maps onto block RAM. An entry is only ever read
  // after it has been written, so its power-up contents are never visible.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] data_out_reg;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             full, empty;
  logic             wr_accept, rd_accept;

  // Flags come only from the registered count (pre-edge state). A write while
  // full is refused even if a read frees a slot in the same cycle, and a read
  // while empty is refused even if a write arrives in the same cycle.
  assign full      = (count_reg == DEPTH_C);
  assign empty     = (count_reg == '0);
  assign wr_accept = EN_w && !full;
  assign rd_accept = EN_r && !empty;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    // Pointers are exactly AW bits, so DEPTH-1 + 1 wraps to 0 on its own.
    if (wr_accept) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_accept) rd_ptr_next = rd_ptr_reg + 1'b1;

    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // Clear first, then set, so a new error in the clearing cycle survives.
    if (CLR_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (EN_w && full)  overflow_next  = 1'b1;
    if (EN_r && empty) underflow_next = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (wr_accept) mem[wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      if (rd_accept) data_out_reg <= mem[rd_ptr_reg];
    end
  end

  assign data_out     = data_out_reg;
  assign count        = count_reg;
  assign Full         = full;
  assign Empty        = empty;
  assign Almost_full  = (count_reg >= AF_C);
  assign Almost_empty = (count_reg <= AE_C);
  assign Overflow     = overflow_reg;
  assign Underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_flags
//
// Directed bench for fifo_sync_flags at DEPTH=8, WIDTH=8, AF_LEVEL=6,
// AE_LEVEL=2. Inputs change 1 ns after a rising edge; outputs are sampled at
// the same point, i.e. after the edge has settled and well before the next.
// -----------------------------------------------------------------------------
module tb_fifo_sync_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst_n;
  logic             en_w;
  logic [WIDTH-1:0] data_in;
  logic             en_r;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, almost_full, almost_empty;
  logic [3:0]       count;
  logic             overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];

  fifo_sync_flags #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .CLK(clk), .RST_n(rst_n), .EN_w(en_w), .data_in(data_in), .EN_r(en_r),
    .CLR_err(clr_err), .data_out(data_out), .Full(full), .Empty(empty),
    .Almost_full(almost_full), .Almost_empty(almost_empty), .count(count),
    .Overflow(overflow), .Underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_w = 1'b0; en_r = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_w = 1'b1; en_r = 1'b1; clr_err = 1'b0; data_in = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({data_out, count, empty, almost_empty, full, almost_full, overflow, underflow}
          !== {8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset cyc%0d dout=%0h cnt=%0d E=%b AE=%b F=%b AF=%b OV=%b UN=%b exp 0 0 1 1 0 0 0 0",
                 i, data_out, count, empty, almost_empty, full, almost_full, overflow, underflow);
      end
      $display("reset cycle %0d: cnt=%0d E=%b", i, count, empty);
    end
    idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      en_w = 1'b1; data_in = 8'(8'h11 + i);
      step();
      checks++;
      if ({count, empty, almost_empty, almost_full, full}
          !== {4'(i + 1), 1'b0, (i + 1) <= 2, (i + 1) >= 6, (i + 1) == 8}) begin
        errors++;
        $display("FAIL fill%0d cnt=%0d E=%b AE=%b AF=%b F=%b exp cnt=%0d E=0 AE=%b AF=%b F=%b",
                 i, count, empty, almost_empty, almost_full, full,
                 i + 1, (i + 1) <= 2, (i + 1) >= 6, (i + 1) == 8);
      end
      $display("write %0h: cnt=%0d AE=%b AF=%b F=%b", data_in, count, almost_empty, almost_full, full);
    end
    data_in = 8'h99;
    step();
    en_w = 1'b0;
    checks++;
    if ({overflow, count, full} !== {1'b1, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL overflow OV=%b cnt=%0d F=%b exp OV=1 cnt=8 F=1", overflow, count, full);
    end
    $display("write while full: OV=%b cnt=%0d", overflow, count);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      en_r = 1'b1;
      step();
      checks++;
      if ({data_out, count, empty} !== {8'(8'h11 + i), 4'(7 - i), i == 7}) begin
        errors++;
        $display("FAIL drain%0d dout=%0h cnt=%0d E=%b exp dout=%0h cnt=%0d E=%b",
                 i, data_out, count, empty, 8'h11 + i, 7 - i, i == 7);
      end
      $display("read %0h: cnt=%0d E=%b", data_out, count, empty);
    end
    step();
    en_r = 1'b0;
    checks++;
    if ({underflow, overflow, data_out, count} !== {1'b1, 1'b1, 8'h18, 4'd0}) begin
      errors++;
      $display("FAIL underflow UN=%b OV=%b dout=%0h cnt=%0d exp UN=1 OV=1 dout=18 cnt=0",
               underflow, overflow, data_out, count);
    end
    $display("read while empty: UN=%b dout=%0h", underflow, data_out);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++;
      $display("FAIL clr_err OV=%b UN=%b exp 0 0", overflow, underflow);
    end
    $display("clear errors: OV=%b UN=%b", overflow, underflow);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) begin
      en_w = 1'b1; data_in = 8'(8'h21 + i);
      step();
    end
    // Full: read accepted, write rejected.
    en_w = 1'b1; en_r = 1'b1; data_in = 8'hEE;
    step();
    idle();
    checks++;
    if ({count, overflow, data_out} !== {4'd7, 1'b1, 8'h21}) begin
      errors++;
      $display("FAIL sim_full cnt=%0d OV=%b dout=%0h exp cnt=7 OV=1 dout=21", count, overflow, data_out);
    end
    $display("both at full: cnt=%0d OV=%b dout=%0h", count, overflow, data_out);
    for (int i = 0; i < 7; i++) begin
      en_r = 1'b1;
      step();
      checks++;
      if (data_out !== 8'(8'h22 + i)) begin
        errors++;
        $display("FAIL sim_drain%0d dout=%0h exp %0h", i, data_out, 8'h22 + i);
      end
    end
    en_r = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    // Empty: write accepted, read rejected.
    en_w = 1'b1; en_r = 1'b1; data_in = 8'h55;
    step();
    idle();
    checks++;
    if ({count, underflow, overflow, data_out} !== {4'd1, 1'b1, 1'b0, 8'h28}) begin
      errors++;
      $display("FAIL sim_empty cnt=%0d UN=%b OV=%b dout=%0h exp cnt=1 UN=1 OV=0 dout=28",
               count, underflow, overflow, data_out);
    end
    $display("both at empty: cnt=%0d UN=%b", count, underflow);
    for (int i = 0; i < 3; i++) begin
      en_w = 1'b1; data_in = 8'(8'h56 + i);
      step();
    end
    // Middle: both accepted, count unchanged.
    en_w = 1'b1; en_r = 1'b1; data_in = 8'h59;
    step();
    idle();
    checks++;
    if ({count, data_out} !== {4'd4, 8'h55}) begin
      errors++;
      $display("FAIL sim_mid cnt=%0d dout=%0h exp cnt=4 dout=55", count, data_out);
    end
    $display("both at 4: cnt=%0d dout=%0h", count, data_out);
    q = {8'h56, 8'h57, 8'h58, 8'h59};
  endtask

  task automatic test_wrap();
    int written = 0;
    int iter = 0;
    logic w, r;
    logic [WIDTH-1:0] exp_d;
    while (written < 20 && iter < 400) begin
      iter++;
      w = (q.size() < 7) && ($urandom_range(0, 1) == 1);
      r = (q.size() > 1) && ($urandom_range(0, 1) == 1);
      en_w = w; en_r = r; data_in = 8'($urandom_range(0, 255));
      step();
      exp_d = 8'h00;
      if (r) exp_d = q.pop_front();
      if (w) begin
        q.push_back(data_in);
        written++;
      end
      checks++;
      if (count !== 4'(q.size())) begin
        errors++;
        $display("FAIL wrap_cnt it%0d cnt=%0d exp %0d", iter, count, q.size());
      end
      if (r) begin
        checks++;
        if (data_out !== exp_d) begin
          errors++;
          $display("FAIL wrap_data it%0d dout=%0h exp %0h", iter, data_out, exp_d);
        end
      end
      $display("wrap it%0d w=%b r=%b dout=%0h cnt=%0d", iter, w, r, data_out, count);
    end
    idle();
    checks++;
    if (written < 20) begin
      errors++;
      $display("FAIL wrap_budget written=%0d exp 20", written);
    end
    while (q.size() > 0) begin
      en_r = 1'b1;
      step();
      exp_d = q.pop_front();
      checks++;
      if (data_out !== exp_d) begin
        errors++;
        $display("FAIL wrap_tail dout=%0h exp %0h", data_out, exp_d);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      en_w = 1'b1; data_in = 8'(8'h61 + i);
      step();
    end
    en_w = 1'b0; en_r = 1'b1;
    step();
    en_r = 1'b0;
    checks++;
    if ({count, data_out} !== {4'd5, 8'h61}) begin
      errors++;
      $display("FAIL pre_reset cnt=%0d dout=%0h exp cnt=5 dout=61", count, data_out);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({count, data_out, empty, almost_empty, full, almost_full} !== {4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset cnt=%0d dout=%0h E=%b AE=%b F=%b AF=%b exp 0 0 1 1 0 0",
               count, data_out, empty, almost_empty, full, almost_full);
    end
    $display("async reset: cnt=%0d dout=%0h E=%b", count, data_out, empty);
    rst_n = 1'b1;
    step();
    en_w = 1'b1; data_in = 8'hAB;
    step();
    en_w = 1'b0; en_r = 1'b1;
    step();
    en_r = 1'b0;
    checks++;
    if ({data_out, count} !== {8'hAB, 4'd0}) begin
      errors++;
      $display("FAIL post_reset dout=%0h cnt=%0d exp dout=ab cnt=0", data_out, count);
    end
    $display("post-reset write/read: dout=%0h", data_out);
  endtask

  initial begin
    rst_n = 1'b0; en_w = 1'b0; en_r = 1'b0; clr_err = 1'b0; data_in = '0;
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
